// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
// Request uses a valid/ready handshake; the response is valid-only and arrives in order.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the IF/ID pipe register
// One imem request outstanding at most; one fetched instruction buffered for IF/ID.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst,
   fetch_unit_if.master       imem,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               if_valid,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_instr
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] instr_q, instr_d;

   logic        req_valid;
   logic        req_accept;
   logic        consume;

   assign consume    = valid_q & ~stall;
   // A request may only go out if the buffer will be free when the response lands.
   assign req_valid  = ~rst & (state_q == S_REQ) & (~valid_q | ~stall);
   assign req_accept = req_valid & imem.imem_req_ready;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;

   assign if_valid = valid_q;
   assign if_pc    = if_pc_q;
   assign if_instr = instr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         if_pc_q <= 32'h0000_0000;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         if_pc_q <= if_pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if_pc_d = if_pc_q;
      instr_d = instr_q;

      if (consume) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end

      case (state_q)
         S_REQ: begin
            // A response seen here is a protocol error and is ignored.
            if (req_accept) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_rsp_valid) begin
               valid_d = 1'b1;
               if_pc_d = pc_q;
               instr_d = imem.imem_rsp_data;
               pc_d    = pc_q + 32'd4;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (imem.imem_rsp_valid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase

      // Redirect overrides everything above, including a refill from a live response.
      if (redirect_valid) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         pc_d    = {redirect_pc[31:2], 2'b00};
         if_pc_d = if_pc_q;
         case (state_q)
            S_REQ:   state_d = req_accept ? S_DROP : S_REQ;
            S_WAIT:  state_d = imem.imem_rsp_valid ? S_REQ : S_DROP;
            S_DROP:  state_d = imem.imem_rsp_valid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   int vectors;
   int miscompares;

   fetch_unit_if imem ();

   fetch_unit #(
      .RESET_PC  (32'h0000_0100),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_buf(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
      chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_instr"}, if_instr, ins);
   endtask

   task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
      chk({tag, "_reqv"}, {31'd0, imem.imem_req_valid}, {31'd0, v});
      if (v) chk({tag, "_addr"}, imem.imem_req_addr, addr);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data = 32'h0;

      // reset state
      #1;
      chk_req("rst", 1'b0, 32'h0);
      chk_buf("rst", 1'b0, 32'h0, 32'h13);
      tick();
      tick();
      rst = 1'b0;

      // back-to-back fetch with 1-cycle memory
      imem.imem_req_ready = 1'b1;
      #1 chk_req("c0", 1'b1, 32'h100);
      tick();
      chk_req("c1", 1'b0, 32'h0);
      chk_buf("c1", 1'b0, 32'h0, 32'h13);
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hA;
      tick();
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("c2", 1'b1, 32'h100, 32'hA);
      chk_req("c2", 1'b1, 32'h104);
      tick();
      chk_buf("c3", 1'b0, 32'h100, 32'h13);
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hB;
      tick();
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("c4", 1'b1, 32'h104, 32'hB);
      chk_req("c4", 1'b1, 32'h108);
      tick();
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hC;
      tick();
      imem.imem_rsp_valid = 1'b0;

      // hold while stalled
      stall = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk_buf("stall", 1'b1, 32'h108, 32'hC);
         chk_req("stall", 1'b0, 32'h0);
         tick();
      end
      stall = 1'b0;
      #1 chk_req("unstall", 1'b1, 32'h10C);
      tick();
      chk_buf("unstall_done", 1'b0, 32'h108, 32'h13);
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hD;
      tick();
      imem.imem_rsp_valid = 1'b0;

      // request backpressure
      imem.imem_req_ready = 1'b0;
      #1 chk_buf("bp_buf", 1'b1, 32'h10C, 32'hD);
      for (int i = 0; i < 4; i++) begin
         chk_req("bp", 1'b1, 32'h110);
         tick();
      end
      imem.imem_req_ready = 1'b1;
      #1 chk_req("bp_acc", 1'b1, 32'h110);
      tick();
      chk_req("bp_wait", 1'b0, 32'h0);

      // redirect during WAIT, response arrives later and is dropped
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      #1 chk_req("drop", 1'b0, 32'h0);
      tick();
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hDEAD;
      tick();
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("nodead", 1'b0, 32'h10C, 32'h13);
      chk_req("redir", 1'b1, 32'h200);
      tick();
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hE;
      tick();
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("redir_buf", 1'b1, 32'h200, 32'hE);
      chk_req("redir_next", 1'b1, 32'h204);
      tick();

      // simultaneous redirect and response in WAIT
      redirect_valid = 1'b1; redirect_pc = 32'h303;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hF;
      tick();
      redirect_valid = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("simul", 1'b0, 32'h200, 32'h13);
      chk_req("simul", 1'b1, 32'h300);

      // protocol-error response in REQ is ignored
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'hBAD;
      tick();
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("proterr", 1'b0, 32'h200, 32'h13);
      chk_req("proterr", 1'b1, 32'h300);

      // pc wrap through a redirect to the top word
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      imem.imem_req_ready = 1'b1;
      #1 chk_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
      tick();
      imem.imem_rsp_valid = 1'b1; imem.imem_rsp_data = 32'h1234;
      tick();
      imem.imem_rsp_valid = 1'b0;
      #1 chk_buf("wrap_buf", 1'b1, 32'hFFFF_FFFC, 32'h1234);
      chk_req("wrap_next", 1'b1, 32'h0);
      tick();

      // async reset while in WAIT
      #1 rst = 1'b1;
      #1 chk_buf("arst", 1'b0, 32'h0, 32'h13);
      chk_req("arst", 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      #1 chk_req("arst_rel", 1'b1, 32'h100);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
